// File: rtl/seven_segment_decoder.sv
// Glitch-filtered seven-segment decoder: recovers hex nibbles from an active-low
// segment bus and hands each new digit out over valid/ready with overrun flagging.
module seven_segment_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic [3:0] out_value,
  output logic       out_illegal,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_overrun
);

  localparam logic [6:0]       BLANK   = 7'h7F;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e           state_q, state_d;
  logic [6:0]       seg_q;
  logic [6:0]       last_emit_q, last_emit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       value_q, value_d;
  logic             illegal_q, illegal_d;
  logic             overrun_q, overrun_d;
  logic             stable, evt, load;
  logic [3:0]       dec_value;
  logic             dec_illegal;

  always_comb begin
    dec_value   = 4'h0;
    dec_illegal = 1'b0;
    case (seg_q)
      7'h40: dec_value = 4'h0;
      7'h79: dec_value = 4'h1;
      7'h24: dec_value = 4'h2;
      7'h30: dec_value = 4'h3;
      7'h19: dec_value = 4'h4;
      7'h12: dec_value = 4'h5;
      7'h02: dec_value = 4'h6;
      7'h78: dec_value = 4'h7;
      7'h00: dec_value = 4'h8;
      7'h10: dec_value = 4'h9;
      7'h08: dec_value = 4'hA;
      7'h03: dec_value = 4'hB;
      7'h46: dec_value = 4'hC;
      7'h21: dec_value = 4'hD;
      7'h06: dec_value = 4'hE;
      7'h0E: dec_value = 4'hF;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Counter saturates so a held pattern stays stable without wrapping.
  always_comb begin
    cnt_d = '0;
    if (seg_in == seg_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  assign stable = (cnt_q == CNT_MAX);
  assign evt    = stable && (seg_q != BLANK) && (seg_q != last_emit_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      seg_q       <= BLANK;
      cnt_q       <= '0;
      last_emit_q <= BLANK;
      value_q     <= 4'h0;
      illegal_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_in;
      cnt_q       <= cnt_d;
      last_emit_q <= last_emit_d;
      value_q     <= value_d;
      illegal_q   <= illegal_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (evt) state_d = FULL;
      FULL:  if (out_ready && !evt) state_d = EMPTY;
    endcase
  end

  // A dropped digit still updates last_emit so it is never retried.
  always_comb begin
    load        = evt && ((state_q == EMPTY) || out_ready);
    value_d     = load ? dec_value : value_q;
    illegal_d   = load ? dec_illegal : illegal_q;
    overrun_d   = evt && (state_q == FULL) && !out_ready;
    last_emit_d = last_emit_q;
    if (stable && (seg_q == BLANK)) begin
      last_emit_d = BLANK;
    end else if (evt) begin
      last_emit_d = seg_q;
    end
  end

  assign out_valid   = (state_q == FULL);
  assign out_value   = value_q;
  assign out_illegal = illegal_q;
  assign out_overrun = overrun_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: directed scenarios plus randomized traffic
// checked against a sample-history reference model.
module tb_seven_segment_decoder;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] seg_in = 7'h7F;
  logic [3:0] out_value;
  logic       out_illegal;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seven_segment_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .out_value   (out_value),
    .out_illegal (out_illegal),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_overrun (out_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: a pattern is stable when the last S samples are identical.
  logic [6:0] hist [$];
  logic [6:0] m_last, m_cur;
  logic       m_valid, m_ovr, m_st, m_ev;
  logic [4:0] m_dat;
  logic [4:0] m_acc [$];
  logic [4:0] d_acc [$];
  int         m_ovr_cnt = 0;
  int         d_ovr_cnt = 0;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph[i] == p) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist    = '{7'h7F};
      m_valid = 1'b0;
      m_dat   = 5'h00;
      m_ovr   = 1'b0;
      m_last  = 7'h7F;
    end else begin
      m_cur = hist[$];
      m_st  = (hist.size() >= S);
      for (int i = 0; i < S && m_st; i++) if (hist[hist.size()-1-i] != m_cur) m_st = 1'b0;
      m_ev = m_st && (m_cur != 7'h7F) && (m_cur != m_last);
      if (m_valid && out_ready) m_acc.push_back(m_dat);
      m_ovr = m_valid && !out_ready && m_ev;
      if (m_ovr) m_ovr_cnt++;
      if (m_st && m_cur == 7'h7F) m_last = 7'h7F;
      if (m_ev) begin
        m_last = m_cur;
        if (!m_valid || out_ready) begin
          m_valid = 1'b1;
          m_dat   = ref_decode(m_cur);
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      hist.push_back(seg_in);
      if (hist.size() > S) void'(hist.pop_front());
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) d_acc.push_back({out_illegal, out_value});
      if (out_overrun) d_ovr_cnt++;
    end
  end

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    d_acc.delete();
    m_acc.delete();
    d_ovr_cnt = 0;
    m_ovr_cnt = 0;
  endtask

  task automatic test_reset();
    int edges;
    seg_in    = 7'h40;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_tests++; if (out_value !== 4'h0) begin n_fail++; $display("FAIL reset_value: got %h want 0", out_value); end
    n_tests++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", out_illegal); end
    n_tests++; if (out_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", out_overrun); end
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      #1;
    end
    n_tests++; if (edges != S + 1) begin n_fail++; $display("FAIL reset_latency: got %0d edges want %0d", edges, S + 1); end
    n_tests++; if ({out_illegal, out_value} !== 5'h00) begin n_fail++; $display("FAIL reset_first_digit: got %h want 00", {out_illegal, out_value}); end
    @(negedge clk);
    hold(7'h40, 50);
    n_tests++; if (d_acc.size() != 1) begin n_fail++; $display("FAIL reset_accept_count: got %0d want 1", d_acc.size()); end
    else begin
      n_tests++; if (d_acc[0] !== 5'h00) begin n_fail++; $display("FAIL reset_accept_value: got %h want 00", d_acc[0]); end
    end
  endtask

  task automatic test_sweep();
    out_ready = 1'b1;
    hold(7'h7F, 6);
    clear_logs();
    for (int i = 0; i < 16; i++) hold(glyph[i], 6);
    hold(7'h7F, 3);
    n_tests++; if (d_acc.size() != 16) begin n_fail++; $display("FAIL sweep_count: got %0d want 16", d_acc.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        n_tests++;
        if (d_acc[i] !== {1'b0, 4'(i)}) begin n_fail++; $display("FAIL sweep_digit%0d: got %h want %h", i, d_acc[i], {1'b0, 4'(i)}); end
      end
    end
    n_tests++; if (d_ovr_cnt != 0) begin n_fail++; $display("FAIL sweep_overrun: got %0d want 0", d_ovr_cnt); end
  endtask

  task automatic test_glitch();
    out_ready = 1'b1;
    hold(7'h7F, 6);
    clear_logs();
    hold(7'h79, 2);
    hold(7'h24, 10);
    n_tests++; if (d_acc.size() != 1) begin n_fail++; $display("FAIL glitch_count: got %0d want 1", d_acc.size()); end
    else begin
      n_tests++; if (d_acc[0] !== 5'h02) begin n_fail++; $display("FAIL glitch_digit: got %h want 02", d_acc[0]); end
    end
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    hold(7'h7F, 6);
    clear_logs();
    hold(7'h30, 6);
    hold(7'h19, 8);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b want 1", out_valid); end
    n_tests++; if (out_value !== 4'h3) begin n_fail++; $display("FAIL overrun_held_value: got %h want 3", out_value); end
    n_tests++; if (d_ovr_cnt != 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d want 1", d_ovr_cnt); end
    out_ready = 1'b1;
    hold(7'h19, 6);
    n_tests++; if (d_acc.size() != 1) begin n_fail++; $display("FAIL overrun_accepts: got %0d want 1", d_acc.size()); end
    else begin
      n_tests++; if (d_acc[0] !== 5'h03) begin n_fail++; $display("FAIL overrun_digit: got %h want 03", d_acc[0]); end
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal_and_blank();
    out_ready = 1'b0;
    hold(7'h7F, 6);
    clear_logs();
    hold(7'h7E, 6);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_valid: got %b want 1", out_valid); end
    n_tests++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b want 1", out_illegal); end
    n_tests++; if (out_value !== 4'h0) begin n_fail++; $display("FAIL illegal_value: got %h want 0", out_value); end
    out_ready = 1'b1;
    hold(7'h40, 6);
    hold(7'h7F, 6);
    hold(7'h40, 6);
    hold(7'h7F, 4);
    n_tests++; if (d_acc.size() != 3) begin n_fail++; $display("FAIL blank_count: got %0d want 3", d_acc.size()); end
    else begin
      n_tests++; if (d_acc[0] !== 5'h10) begin n_fail++; $display("FAIL blank_illegal_entry: got %h want 10", d_acc[0]); end
      n_tests++; if (d_acc[1] !== 5'h00 || d_acc[2] !== 5'h00) begin n_fail++; $display("FAIL blank_reemit: got %h %h want 00 00", d_acc[1], d_acc[2]); end
    end
  endtask

  task automatic test_async_reset();
    int edges;
    out_ready = 1'b0;
    hold(7'h12, 7);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_full: got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_immediate: got %b want 0", out_valid); end
    @(negedge clk);
    out_ready = 1'b1;
    clear_logs();
    rst_n = 1'b1;
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      #1;
    end
    n_tests++; if (edges != S + 1) begin n_fail++; $display("FAIL areset_reemit_latency: got %0d edges want %0d", edges, S + 1); end
    n_tests++; if ({out_illegal, out_value} !== 5'h05) begin n_fail++; $display("FAIL areset_reemit_digit: got %h want 05", {out_illegal, out_value}); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int r, len;
    logic [6:0] p;
    clear_logs();
    for (int seg = 0; seg < 60; seg++) begin
      r = $urandom_range(0, 19);
      if (r < 16) p = glyph[r];
      else if (r < 18) p = 7'h7F;
      else p = 7'($urandom);
      seg_in = p;
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        n_tests++;
        if ({out_valid, out_illegal, out_value, out_overrun} !== {m_valid, m_dat, m_ovr}) begin
          n_fail++;
          $display("FAIL random_cycle: got v%b i%b d%h o%b want v%b i%b d%h o%b",
                   out_valid, out_illegal, out_value, out_overrun, m_valid, m_dat[4], m_dat[3:0], m_ovr);
        end
      end
    end
    out_ready = 1'b1;
    hold(7'h7F, 8);
    n_tests++; if (d_acc.size() != m_acc.size()) begin n_fail++; $display("FAIL random_accept_count: got %0d want %0d", d_acc.size(), m_acc.size()); end
    else begin
      for (int i = 0; i < d_acc.size(); i++) begin
        n_tests++;
        if (d_acc[i] !== m_acc[i]) begin n_fail++; $display("FAIL random_accept%0d: got %h want %h", i, d_acc[i], m_acc[i]); end
      end
    end
    n_tests++; if (d_ovr_cnt != m_ovr_cnt) begin n_fail++; $display("FAIL random_overruns: got %0d want %0d", d_ovr_cnt, m_ovr_cnt); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_glitch();
    test_overrun();
    test_illegal_and_blank();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
